if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage between the next-PC select mux (upstream) and decode (downstream).
- Holds the architectural fetch PC and issues one-at-a-time requests to instruction memory over a valid/ready handshake.
- Buffers returned instructions in a small FIFO toward decode, and flushes/redirects when the execute-resolved target arrives.
- Drives `npc` (PC+4) back to the next-PC mux.

Parameters:
- RESET_PC, 64'h0000_0000_0000_0000, fetch address after reset.
- DEPTH, 2, instruction buffer entries (power of two, >=2).
- INST_W, 32, instruction width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  next-PC mux selected a non-sequential target (jump or taken branch).
- redirect_pc  in  64  target from next-PC mux.
- npc  out  64  fetch PC + 4, to next-PC mux.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  64  fetch address.
- imem_resp_valid  in  1  instruction returned (no backpressure; must be accepted).
- imem_resp_data  in  INST_W  returned instruction.
- if_valid  out  1  buffer head valid toward decode.
- if_ready  in  1  decode accepts head (low = stall).
- if_pc  out  64  PC of head instruction.
- if_inst  out  INST_W  head instruction.

Behaviour:
- Reset (async, rst=1):
  - pc_q=RESET_PC, state=IDLE, count=0.
  - imem_req_valid=0, if_valid=0, if_pc=0, if_inst=0, npc=RESET_PC+4.
- Outputs:
  - npc = pc_q + 4, combinational, wraps mod 2^64.
  - imem_req_addr = pc_q.
  - imem_req_valid = (state==REQ).
- FSM states: IDLE, REQ, WAIT, DROP, HOLD.
  - IDLE: next cycle -> REQ. Exists only so no request goes out in the reset-release cycle.
  - REQ: on imem_req_ready -> WAIT; else stay.
  - WAIT: on imem_resp_valid:
    - push {pc_q, imem_resp_data} into the buffer, pc_q <= pc_q+4.
    - go to REQ if post-push count < DEPTH, else HOLD.
  - HOLD: go to REQ once count < DEPTH (i.e. after a pop).
  - DROP: on imem_resp_valid, discard the data -> REQ. pc_q is unchanged.
- Issue rule: at most one outstanding request. Occupancy + in-flight never exceeds DEPTH, so a response always finds space.
- Redirect (redirect_valid=1) has highest priority in any state:
  - pc_q <= {redirect_pc[63:2],2'b00}.
  - Buffer flushed (count=0); if_valid=0 next cycle, regardless of a same-cycle pop.
  - State transitions:
    - IDLE -> IDLE.
    - REQ with ready=0 -> REQ (new address next cycle).
    - REQ with ready=1 -> DROP (old request was accepted).
    - WAIT with resp_valid=0 -> DROP.
    - WAIT with resp_valid=1 -> REQ (response discarded, not pushed).
    - DROP -> DROP, or REQ if resp_valid the same cycle.
    - HOLD -> REQ.
- Buffer:
  - Circular, rd/wr pointers of log2(DEPTH) bits wrapping naturally.
  - if_valid = count!=0; head fields are registered buffer contents.
  - Pop on if_valid & if_ready.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Empty buffer with a push: head visible the cycle after the response (no bypass). Fetch latency = request accept + response + 1 cycle.
- Stall: if_ready=0 holds head stable; fetching continues until the buffer is full, then HOLD.
- Reset mid-operation: immediate return to the reset values. A later stray imem_resp_valid in IDLE/REQ is ignored.

Decomposition:
- Shared pipeline package:
  - XLEN=64 and INST_W=32 constants.
  - RESET_PC default.
  - fetch-state enum {IDLE, REQ, WAIT, DROP, HOLD}.
  - IF/ID bundle typedef {pc, inst}.
- One sub-module: if_inst_fifo. Parameterised DEPTH/width, synchronous flush, push/pop/count, async reset.

Test Plan:
- Boot: rst 1->0, ready=1, 1-cycle response. Request addr 0x0 issued in the 2nd post-reset cycle. if_pc/if_inst = 0x0/0x00000013, then 0x4, 0x8; npc tracks 0x4, 0x8, 0xC.
- Stall: if_ready=0 after two fetches. Buffer fills (count=2), state HOLD, imem_req_valid=0. Release if_ready: pops 0x0 then 0x4, and fetch of 0x8 resumes.
- Redirect in WAIT: redirect_pc=0x1000 while the 0x8 response is pending. The late 0x8 response is dropped (DROP), next request addr=0x1000, first if_pc=0x1000, buffer flushed.
- Redirect with simultaneous REQ accept (ready=1) and with simultaneous response: first case goes to DROP; second goes directly to REQ at 0x2000. No stale instruction ever reaches if_valid.
- Redirect and pop same cycle with count=2: next cycle if_valid=0, count=0. redirect_pc=0x2002 gives fetch addr 0x2000.
- Async reset asserted in WAIT: outputs zero immediately (imem_req_valid=0, if_valid=0). The stray response after deassert is ignored, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage.
//   XLEN / INST_W    : datapath widths
//   RESET_PC_DEFAULT : fetch address after reset
//   fetch_state_e    : fetch sequencer states
//   if_id_t          : IF/ID bundle handed to decode
package if_fetch_stage_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned INST_W = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DROP,
    ST_HOLD
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } if_id_t;

endpackage

// File: rtl/if_inst_fifo.sv
// Circular instruction buffer between fetch and decode.
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : synchronous clear of pointers and count (wins over push/pop)
//   push, push_data : write one entry
//   pop        : retire the head entry
//   head_data  : registered contents of the head slot
//   count      : current occupancy (0..DEPTH)
module if_inst_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 96
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    do_pop  = pop && (count_q != '0);
    do_push = push && ((count_q != FULL) || do_pop);
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = push_data;
        wr_d        = wr_q + AW'(1);
      end
      if (do_pop) begin
        rd_d = rd_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign head_data = mem_q[rd_q];
  assign count     = count_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage.
//   clk, rst                     : clock, asynchronous active-high reset
//   redirect_valid, redirect_pc  : non-sequential target from the next-PC mux
//   npc                          : fetch PC + 4 back to the next-PC mux
//   imem_req_valid/ready/addr    : single-outstanding fetch request
//   imem_resp_valid/data         : returned instruction (always accepted)
//   if_valid/ready, if_pc/inst   : buffered head toward decode
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned INST_W   = if_fetch_stage_pkg::INST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [63:0]       redirect_pc,
  output logic [63:0]       npc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [63:0]       imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [63:0]       if_pc,
  output logic [INST_W-1:0] if_inst
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = XLEN + INST_W;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            push, pop, flush;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_after_push;
  logic [EW-1:0]   head;
  logic            unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign pop              = if_valid && if_ready;
  assign count_after_push = pop ? count : count + CW'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    if (redirect_valid) begin
      // Redirect overrides everything; a request already accepted by memory
      // still owes a response, so those paths park in DROP to swallow it.
      pc_d  = {redirect_pc[63:2], 2'b00};
      flush = 1'b1;
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_REQ:  state_d = imem_req_ready  ? ST_DROP : ST_REQ;
        ST_WAIT: state_d = imem_resp_valid ? ST_REQ  : ST_DROP;
        ST_DROP: state_d = imem_resp_valid ? ST_REQ  : ST_DROP;
        ST_HOLD: state_d = ST_REQ;
        default: state_d = ST_IDLE;
      endcase
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_REQ;
        ST_REQ: begin
          if (imem_req_ready) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_resp_valid) begin
            push    = 1'b1;
            pc_d    = pc_q + 64'd4;
            state_d = (count_after_push < FULL) ? ST_REQ : ST_HOLD;
          end
        end
        ST_DROP: begin
          if (imem_resp_valid) state_d = ST_REQ;
        end
        ST_HOLD: begin
          if (count < FULL) state_d = ST_REQ;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  if_inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data ({pc_q, imem_resp_data}),
    .pop       (pop),
    .head_data (head),
    .count     (count)
  );

  assign npc            = pc_q + 64'd4;
  assign imem_req_addr  = pc_q;
  assign imem_req_valid = (state_q == ST_REQ);
  assign if_valid       = (count != '0);
  assign if_pc          = head[EW-1:INST_W];
  assign if_inst        = head[INST_W-1:0];

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [63:0] npc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic        if_ready;
  logic [63:0] if_pc;
  logic [31:0] if_inst;

  always #5 clk = ~clk;

  if_fetch_stage #(
    .RESET_PC (64'h0),
    .DEPTH    (2),
    .INST_W   (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .npc             (npc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_pc           (if_pc),
    .if_inst         (if_inst)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model: program-order PC stream seen by decode, plus a memory
  // responder that returns a fixed function of the address.
  logic [63:0] exp_pc = 64'h0;
  int unsigned delivered = 0;
  bit          rsp_pending = 1'b0;
  logic [63:0] rsp_addr = 64'h0;
  int unsigned rsp_wait = 0;
  int unsigned lat_lo = 0, lat_hi = 0;
  int unsigned ready_mode = 1;  // 0 low, 1 high, 2 random
  int unsigned ifr_mode   = 0;
  int unsigned redir_rate = 0;  // 0 = no random redirects

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] + 32'h13;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic pick(input int unsigned mode);
    if (mode == 2) return 1'($urandom_range(1, 0));
    return (mode == 1);
  endfunction

  task automatic tick();
    logic        acc, popd, resp_now;
    logic [63:0] acc_addr;
    acc      = imem_req_valid && imem_req_ready;
    acc_addr = imem_req_addr;
    popd     = if_valid && if_ready;
    resp_now = imem_resp_valid;
    chk("one_outstanding", {63'b0, imem_req_valid && rsp_pending}, 64'h0);
    if (popd) begin
      chk("pop_pc", if_pc, exp_pc);
      chk("pop_inst", {32'h0, if_inst}, {32'h0, inst_of(exp_pc)});
      exp_pc = exp_pc + 64'd4;
      delivered++;
    end
    if (redirect_valid) exp_pc = {redirect_pc[63:2], 2'b00};
    @(posedge clk);
    #1;
    if (resp_now) rsp_pending = 1'b0;
    if (acc) begin
      rsp_pending = 1'b1;
      rsp_addr    = acc_addr;
      rsp_wait    = $urandom_range(lat_hi, lat_lo);
    end else if (rsp_pending && rsp_wait != 0) begin
      rsp_wait--;
    end
    imem_resp_valid = rsp_pending && (rsp_wait == 0);
    imem_resp_data  = imem_resp_valid ? inst_of(rsp_addr) : $urandom();
    imem_req_ready  = pick(ready_mode);
    if_ready        = pick(ifr_mode);
    if (redir_rate != 0 && $urandom_range(redir_rate - 1, 0) == 0) begin
      redirect_valid = 1'b1;
      redirect_pc    = {$urandom(), $urandom()};
    end else begin
      redirect_valid = 1'b0;
      redirect_pc    = {$urandom(), $urandom()};
    end
  endtask

  task automatic wait_req(input string tag);
    int unsigned n = 0;
    while (!imem_req_valid && n < 40) begin
      tick();
      n++;
    end
    chk(tag, {63'b0, imem_req_valid}, 64'h1);
  endtask

  task automatic wait_head(input string tag);
    int unsigned n = 0;
    while (!if_valid && n < 40) begin
      tick();
      n++;
    end
    chk(tag, {63'b0, if_valid}, 64'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if_ready        = 1'b0;
    rst             = 1'b1;
    #1;
    chk("rst_req_valid", {63'b0, imem_req_valid}, 64'h0);
    chk("rst_if_valid", {63'b0, if_valid}, 64'h0);
    chk("rst_if_pc", if_pc, 64'h0);
    chk("rst_if_inst", {32'h0, if_inst}, 64'h0);
    chk("rst_npc", npc, 64'h4);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("idle_no_req", {63'b0, imem_req_valid}, 64'h0);

    // Boot: request in the second post-reset cycle, one-cycle memory.
    tick();
    chk("boot_req_valid", {63'b0, imem_req_valid}, 64'h1);
    chk("boot_req_addr", imem_req_addr, 64'h0);
    chk("boot_npc", npc, 64'h4);
    tick();
    chk("boot_wait_no_req", {63'b0, imem_req_valid}, 64'h0);
    chk("boot_no_bypass", {63'b0, if_valid}, 64'h0);
    tick();
    chk("boot_head_valid", {63'b0, if_valid}, 64'h1);
    chk("boot_head_pc", if_pc, 64'h0);
    chk("boot_head_inst", {32'h0, if_inst}, 64'h13);
    chk("boot_npc2", npc, 64'h8);
    chk("boot_req_addr2", imem_req_addr, 64'h4);

    // Stall: decode holds off, buffer fills, fetch parks.
    tick();
    tick();
    chk("stall_npc", npc, 64'hC);
    chk("stall_no_req", {63'b0, imem_req_valid}, 64'h0);
    tick(); tick(); tick();
    chk("hold_no_req", {63'b0, imem_req_valid}, 64'h0);
    chk("hold_head_pc", if_pc, 64'h0);
    ifr_mode = 1;
    if_ready = 1'b1;
    tick();
    chk("release_head_pc", if_pc, 64'h4);
    tick();
    chk("resume_req_valid", {63'b0, imem_req_valid}, 64'h1);
    chk("resume_req_addr", imem_req_addr, 64'h8);
    chk("resume_empty", {63'b0, if_valid}, 64'h0);

    // Redirect while the 0x8 response is still pending.
    lat_lo = 3; lat_hi = 3;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h1000;
    tick();
    lat_lo = 0; lat_hi = 0;
    chk("drop_no_req", {63'b0, imem_req_valid}, 64'h0);
    chk("drop_npc", npc, 64'h1004);
    wait_req("drop_done");
    chk("drop_new_addr", imem_req_addr, 64'h1000);
    wait_head("redir_head_seen");
    chk("redir_head_pc", if_pc, 64'h1000);

    // Redirect in the same cycle memory accepts a request.
    wait_req("acc_req_seen");
    redirect_valid = 1'b1;
    redirect_pc    = 64'h3000;
    imem_req_ready = 1'b1;
    tick();
    chk("acc_drop_no_req", {63'b0, imem_req_valid}, 64'h0);
    chk("acc_drop_npc", npc, 64'h3004);
    wait_req("acc_drop_done");
    chk("acc_new_addr", imem_req_addr, 64'h3000);

    // Redirect in the same cycle the response arrives.
    tick();
    chk("resp_wait_no_req", {63'b0, imem_req_valid}, 64'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2000;
    tick();
    chk("resp_redir_req", {63'b0, imem_req_valid}, 64'h1);
    chk("resp_redir_addr", imem_req_addr, 64'h2000);
    chk("resp_redir_empty", {63'b0, if_valid}, 64'h0);

    // Redirect and pop together with a full buffer; unaligned target.
    ifr_mode = 0;
    if_ready = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("full_valid", {63'b0, if_valid}, 64'h1);
    chk("full_no_req", {63'b0, imem_req_valid}, 64'h0);
    chk("full_head_pc", if_pc, 64'h2000);
    ifr_mode       = 1;
    if_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2002;
    tick();
    chk("pop_redir_empty", {63'b0, if_valid}, 64'h0);
    chk("pop_redir_req", {63'b0, imem_req_valid}, 64'h1);
    chk("pop_redir_addr", imem_req_addr, 64'h2000);

    // Async reset while a response is outstanding.
    wait_req("rst_req_seen");
    lat_lo = 3; lat_hi = 3;
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req_valid", {63'b0, imem_req_valid}, 64'h0);
    chk("arst_if_valid", {63'b0, if_valid}, 64'h0);
    chk("arst_npc", npc, 64'h4);
    chk("arst_addr", imem_req_addr, 64'h0);
    chk("arst_if_pc", if_pc, 64'h0);
    rsp_pending     = 1'b0;
    imem_resp_valid = 1'b0;
    exp_pc          = 64'h0;
    lat_lo = 0; lat_hi = 0;
    tick();
    rst             = 1'b0;
    ready_mode      = 0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEADBEEF;
    tick();
    chk("stray_idle_req", {63'b0, imem_req_valid}, 64'h1);
    chk("stray_idle_addr", imem_req_addr, 64'h0);
    chk("stray_idle_empty", {63'b0, if_valid}, 64'h0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEADBEEF;
    tick();
    chk("stray_req_req", {63'b0, imem_req_valid}, 64'h1);
    chk("stray_req_addr", imem_req_addr, 64'h0);
    chk("stray_req_empty", {63'b0, if_valid}, 64'h0);
    ready_mode     = 1;
    imem_req_ready = 1'b1;
    wait_head("restart_head_seen");
    chk("restart_head_pc", if_pc, 64'h0);
    chk("restart_head_inst", {32'h0, if_inst}, 64'h13);

    // Randomised traffic against the program-order model.
    ready_mode = 2;
    ifr_mode   = 2;
    lat_lo = 0; lat_hi = 3;
    redir_rate = 20;
    delivered  = 0;
    for (int i = 0; i < 2000; i++) tick();
    redir_rate = 0;
    ready_mode = 1;
    ifr_mode   = 1;
    for (int i = 0; i < 30; i++) tick();
    chk("random_progress", {63'b0, delivered > 100}, 64'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
